id_ex_stage: RTL

Decode-to-execute pipeline register of the 5-stage core, with integrated load-use hazard detection and register-file write-through capture. It latches decoded operands and control from ID and presents them to EX, where the operand forwarding logic compares `ex_rs1`/`ex_rs2` against the stage-4/5 destinations. A load followed immediately by a dependent instruction cannot be served by forwarding, so this block inserts a one-cycle bubble and stalls IF/ID.

---
 rtl/id_ex_stage_if.sv | 56 +++++
 rtl/id_ex_stage.sv | 97 +++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// ID->EX pipeline register bus: decoded fields in, registered EX fields out,
// plus WB write-through port, pipeline control and hazard status.
interface id_ex_stage_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_rs1_used, id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_rd_valid;
  logic        id_wb_sel;
  logic        id_mem_read, id_mem_write;
  logic [3:0]  id_alu_op;
  logic [31:0] id_imm;
  logic [31:0] id_rdata1, id_rdata2;

  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        flush;
  logic        hold;

  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs1, ex_rs2;
  logic [4:0]  ex_rd;
  logic        ex_rd_valid;
  logic        ex_wb_sel;
  logic        ex_mem_read, ex_mem_write;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_imm;
  logic [31:0] ex_rdata1, ex_rdata2;

  logic        stall_id;
  logic [31:0] bubble_count;

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_valid, id_wb_sel, id_mem_read, id_mem_write,
           id_alu_op, id_imm, id_rdata1, id_rdata2,
           wb_we, wb_rd, wb_data, flush, hold,
    output ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rd_valid, ex_wb_sel,
           ex_mem_read, ex_mem_write, ex_alu_op, ex_imm, ex_rdata1, ex_rdata2,
           stall_id, bubble_count
  );

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_valid, id_wb_sel, id_mem_read, id_mem_write,
           id_alu_op, id_imm, id_rdata1, id_rdata2,
           wb_we, wb_rd, wb_data, flush, hold,
    input  ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rd_valid, ex_wb_sel,
           ex_mem_read, ex_mem_write, ex_alu_op, ex_imm, ex_rdata1, ex_rdata2,
           stall_id, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and WB write-through
// capture of register-file read data.
module id_ex_stage (
  input  logic           clk,
  input  logic           rst_n,
  id_ex_stage_if.slave   bus
);
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_valid;
    logic        wb_sel;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  alu_op;
    logic [31:0] imm;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } ex_t;

  ex_t         ex_q;
  ex_t         cap;
  logic [31:0] cnt_q;
  logic        load_use;

  // A load in EX whose result ID needs cannot be forwarded in time.
  assign load_use = ex_q.valid & ex_q.mem_read & ex_q.rd_valid & (ex_q.rd != 5'd0) &
                    bus.id_valid &
                    ((bus.id_rs1_used & (bus.id_rs1 == ex_q.rd)) |
                     (bus.id_rs2_used & (bus.id_rs2 == ex_q.rd)));

  assign bus.stall_id = load_use & ~bus.flush & ~bus.hold;

  always_comb begin
    cap = '0;
    if (bus.id_valid) begin
      cap.valid     = 1'b1;
      cap.pc        = bus.id_pc;
      cap.rs1       = bus.id_rs1;
      cap.rs2       = bus.id_rs2;
      cap.rd        = bus.id_rd;
      cap.rd_valid  = bus.id_rd_valid;
      cap.wb_sel    = bus.id_wb_sel;
      cap.mem_read  = bus.id_mem_read;
      cap.mem_write = bus.id_mem_write;
      cap.alu_op    = bus.id_alu_op;
      cap.imm       = bus.id_imm;
      // x0 reads as zero; a same-cycle WB write overrides the stale RF read.
      if (bus.id_rs1 == 5'd0)
        cap.rdata1 = '0;
      else if (bus.wb_we && (bus.wb_rd == bus.id_rs1))
        cap.rdata1 = bus.wb_data;
      else
        cap.rdata1 = bus.id_rdata1;
      if (bus.id_rs2 == 5'd0)
        cap.rdata2 = '0;
      else if (bus.wb_we && (bus.wb_rd == bus.id_rs2))
        cap.rdata2 = bus.wb_data;
      else
        cap.rdata2 = bus.id_rdata2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else if (!bus.hold) begin
      if (bus.flush) begin
        ex_q <= '0;
      end else if (load_use) begin
        ex_q  <= '0;
        cnt_q <= cnt_q + 32'd1;
      end else begin
        ex_q <= cap;
      end
    end
  end

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_rs1       = ex_q.rs1;
  assign bus.ex_rs2       = ex_q.rs2;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_rd_valid  = ex_q.rd_valid;
  assign bus.ex_wb_sel    = ex_q.wb_sel;
  assign bus.ex_mem_read  = ex_q.mem_read;
  assign bus.ex_mem_write = ex_q.mem_write;
  assign bus.ex_alu_op    = ex_q.alu_op;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_rdata1    = ex_q.rdata1;
  assign bus.ex_rdata2    = ex_q.rdata2;
  assign bus.bubble_count = cnt_q;
endmodule
